zbt_mbox_arb: RTL and testbench

ZBT_MBOX_ARB -- requirements
Module: zbt_mbox_arb

---
 rtl/zbt_mbox_arb.sv | 181 ++++++++++++++++++
 tb/tb_zbt_mbox_arb.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/zbt_mbox_arb.sv
// Round-robin arbiter that serialises NUM_CH requesters onto one ZBT mailbox
// port. Only one transaction is in flight at a time. Each transaction ends
// with an ack pulse on completion, or an err pulse when the wait counter
// expires. If completion and expiry fall on the same edge, the ack wins.
module zbt_mbox_arb #(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned ADDR_W  = 20,
  parameter int unsigned DATA_W  = 36,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic [NUM_CH-1:0]          ch_req_i,
  input  logic [NUM_CH-1:0]          ch_we_i,
  input  logic [NUM_CH*ADDR_W-1:0]   ch_addr_i,
  input  logic [NUM_CH*DATA_W-1:0]   ch_wdata_i,
  output logic [NUM_CH-1:0]          ch_ack_o,
  output logic [NUM_CH-1:0]          ch_err_o,
  output logic [DATA_W-1:0]          ch_rdata_o,
  output logic                       mbox_sel_o,
  output logic                       mbox_we_o,
  output logic [ADDR_W-1:0]          mbox_addr_o,
  output logic [DATA_W-1:0]          mbox_wdata_o,
  input  logic                       mbox_dval_i,
  input  logic                       mbox_wdone_i,
  input  logic [DATA_W-1:0]          mbox_rdata_i,
  output logic                       busy_o,
  output logic [$clog2(NUM_CH)-1:0]  grant_o
);

  localparam int unsigned GW    = $clog2(NUM_CH);
  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit          TO_EN = (TIMEOUT > 0);
  // Expiry is flagged one count early so err rises exactly TIMEOUT cycles after grant.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic                sel_q, sel_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                busy_q, busy_d;
  logic [NUM_CH-1:0]   ack_q, ack_d;
  logic [NUM_CH-1:0]   err_q, err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [GW-1:0]       grant_q, grant_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [GW-1:0]       idx_s;
  logic [GW-1:0]       pick_s;
  logic                found_s;
  logic                done_s;
  logic                expire_s;

  assign mbox_sel_o   = sel_q;
  assign mbox_we_o    = we_q;
  assign mbox_addr_o  = addr_q;
  assign mbox_wdata_o = wdata_q;
  assign busy_o       = busy_q;
  assign ch_ack_o     = ack_q;
  assign ch_err_o     = err_q;
  assign ch_rdata_o   = rdata_q;
  assign grant_o      = grant_q;

  // Round-robin search: first requester after the last grant, wrapping at NUM_CH-1.
  always_comb begin
    idx_s   = grant_q;
    pick_s  = grant_q;
    found_s = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (idx_s == GW'(NUM_CH - 1)) begin
        idx_s = {GW{1'b0}};
      end else begin
        idx_s = idx_s + GW'(1);
      end
      if (!found_s && ch_req_i[idx_s]) begin
        found_s = 1'b1;
        pick_s  = idx_s;
      end else begin
        pick_s  = pick_s;
      end
    end
  end

  // Completion strobe must match the transaction type; expiry only when enabled.
  always_comb begin
    done_s   = we_q ? mbox_wdone_i : mbox_dval_i;
    expire_s = TO_EN && (cnt_q == CNT_LAST);
  end

  // Next-state and registered-output logic of the IDLE/BUSY controller.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    busy_d  = busy_q;
    ack_d   = {NUM_CH{1'b0}};
    err_d   = {NUM_CH{1'b0}};
    rdata_d = rdata_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (found_s) begin
          state_d = ST_BUSY;
          sel_d   = 1'b1;
          busy_d  = 1'b1;
          grant_d = pick_s;
          we_d    = ch_we_i[pick_s];
          addr_d  = ch_addr_i[pick_s*ADDR_W +: ADDR_W];
          wdata_d = ch_wdata_i[pick_s*DATA_W +: DATA_W];
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (done_s) begin
          ack_d[grant_q] = 1'b1;
          sel_d   = 1'b0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
          if (!we_q) begin
            rdata_d = mbox_rdata_i;
          end else begin
            rdata_d = rdata_q;
          end
        end else if (expire_s) begin
          err_d[grant_q] = 1'b1;
          sel_d   = 1'b0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          cnt_d   = TO_EN ? (cnt_q + CNT_W'(1)) : cnt_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        sel_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset leaves channel 0 as first in line.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      sel_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= {ADDR_W{1'b0}};
      wdata_q <= {DATA_W{1'b0}};
      busy_q  <= 1'b0;
      ack_q   <= {NUM_CH{1'b0}};
      err_q   <= {NUM_CH{1'b0}};
      rdata_q <= {DATA_W{1'b0}};
      grant_q <= GW'(NUM_CH - 1);
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_zbt_mbox_arb.sv
// Bench for zbt_mbox_arb: directed scenarios followed by randomized
// transactions. Expected results come from a transaction-level model.
module tb_zbt_mbox_arb;

  localparam int NUM_CH  = 4;
  localparam int ADDR_W  = 20;
  localparam int DATA_W  = 36;
  localparam int TIMEOUT = 8;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [NUM_CH-1:0]         ch_req, ch_we;
  logic [NUM_CH*ADDR_W-1:0]  ch_addr;
  logic [NUM_CH*DATA_W-1:0]  ch_wdata;
  logic [NUM_CH-1:0]         ch_ack, ch_err;
  logic [DATA_W-1:0]         ch_rdata;
  logic                      mbox_sel, mbox_we;
  logic [ADDR_W-1:0]         mbox_addr;
  logic [DATA_W-1:0]         mbox_wdata;
  logic                      mbox_dval, mbox_wdone;
  logic [DATA_W-1:0]         mbox_rdata;
  logic                      busy;
  logic [1:0]                grant;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: last granted channel and last read data delivered.
  int                last_g;
  logic [DATA_W-1:0] exp_rdata;

  zbt_mbox_arb #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .ch_req_i(ch_req), .ch_we_i(ch_we), .ch_addr_i(ch_addr), .ch_wdata_i(ch_wdata),
    .ch_ack_o(ch_ack), .ch_err_o(ch_err), .ch_rdata_o(ch_rdata),
    .mbox_sel_o(mbox_sel), .mbox_we_o(mbox_we), .mbox_addr_o(mbox_addr),
    .mbox_wdata_o(mbox_wdata), .mbox_dval_i(mbox_dval), .mbox_wdone_i(mbox_wdone),
    .mbox_rdata_i(mbox_rdata), .busy_o(busy), .grant_o(grant)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [ADDR_W-1:0] rnd_a();
    return ADDR_W'($urandom);
  endfunction

  function automatic logic [DATA_W-1:0] rnd_d();
    return DATA_W'({$urandom, $urandom});
  endfunction

  // Round-robin rule: first requester after the last grant.
  function automatic int rr_pick(input int last, input logic [NUM_CH-1:0] req);
    for (int k = 1; k <= NUM_CH; k++) begin
      if (req[(last + k) % NUM_CH]) return (last + k) % NUM_CH;
    end
    return -1;
  endfunction

  task automatic set_req(input int c, input logic we, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d);
    ch_req[c] = 1'b1;
    ch_we[c]  = we;
    ch_addr[c*ADDR_W +: ADDR_W] = a;
    ch_wdata[c*DATA_W +: DATA_W] = d;
  endtask

  // Called at a negedge with the DUT idle and at least one request raised.
  // d = completion edge count after the grant edge (>TIMEOUT: never completes).
  task automatic serve(input int d, input bit force_wrong, input logic [DATA_W-1:0] rd,
                       output int g);
    logic              w;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] wd;
    bit                fin;
    bit                hit;
    bit                bad;
    g  = rr_pick(last_g, ch_req);
    if (g < 0) begin
      $display("FAIL serve_no_request: observed none expected one");
      $fatal(1);
    end
    w  = ch_we[g];
    a  = ch_addr[g*ADDR_W +: ADDR_W];
    wd = ch_wdata[g*DATA_W +: DATA_W];
    @(posedge clk); @(negedge clk);
    mbox_dval = 1'b0; mbox_wdone = 1'b0;
    chk("grant", 64'(grant), 64'(g));
    chk("sel_on", 64'(mbox_sel), 64'(1));
    chk("busy_on", 64'(busy), 64'(1));
    chk("mbox_we", 64'(mbox_we), 64'(w));
    chk("mbox_addr", 64'(mbox_addr), 64'(a));
    chk("mbox_wdata", 64'(mbox_wdata), 64'(wd));
    chk("quiet_at_grant", 64'({ch_ack, ch_err}), 64'(0));
    last_g = g;
    fin = 1'b0;
    for (int j = 1; j <= TIMEOUT && !fin; j++) begin
      hit = (j == d);
      bad = !hit && (force_wrong || ($urandom_range(0, 3) == 0));
      mbox_rdata = hit ? rd : rnd_d();
      if (w) begin
        mbox_wdone = hit; mbox_dval = bad;
      end else begin
        mbox_dval = hit; mbox_wdone = bad;
      end
      // Granted channel inputs wander; the DUT must ignore them while busy.
      ch_req[g] = 1'($urandom_range(0, 1));
      ch_we[g]  = 1'($urandom_range(0, 1));
      ch_addr[g*ADDR_W +: ADDR_W] = rnd_a();
      ch_wdata[g*DATA_W +: DATA_W] = rnd_d();
      @(posedge clk); @(negedge clk);
      mbox_dval = 1'b0; mbox_wdone = 1'b0;
      if (hit) begin
        if (!w) exp_rdata = rd;
        chk("ack", 64'(ch_ack), 64'(1) << g);
        chk("no_err_on_ack", 64'(ch_err), 64'(0));
        fin = 1'b1;
      end else if (j == TIMEOUT) begin
        chk("err", 64'(ch_err), 64'(1) << g);
        chk("no_ack_on_err", 64'(ch_ack), 64'(0));
        fin = 1'b1;
      end else begin
        chk("hold_sel", 64'(mbox_sel), 64'(1));
        chk("hold_addr", 64'(mbox_addr), 64'(a));
        chk("hold_wdata", 64'(mbox_wdata), 64'(wd));
        chk("quiet_busy", 64'({ch_ack, ch_err}), 64'(0));
      end
    end
    chk("sel_off", 64'(mbox_sel), 64'(0));
    chk("busy_off", 64'(busy), 64'(0));
    chk("rdata", 64'(ch_rdata), 64'(exp_rdata));
    ch_req[g] = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_sel"}, 64'(mbox_sel), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_we"}, 64'(mbox_we), 64'(0));
    chk({tag, "_addr"}, 64'(mbox_addr), 64'(0));
    chk({tag, "_wdata"}, 64'(mbox_wdata), 64'(0));
    chk({tag, "_rdata"}, 64'(ch_rdata), 64'(0));
    chk({tag, "_ackerr"}, 64'({ch_ack, ch_err}), 64'(0));
    chk({tag, "_grant"}, 64'(grant), 64'(NUM_CH - 1));
  endtask

  // Assert reset mid-cycle, check outputs before any clock edge, then release.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_vals(tag);
    ch_req = '0;
    last_g = NUM_CH - 1;
    exp_rdata = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int g;
  int fair_seq [5] = '{0, 1, 2, 3, 0};

  initial begin
    rst_n = 1'b0;
    ch_req = '0; ch_we = '0; ch_addr = '0; ch_wdata = '0;
    mbox_dval = 1'b0; mbox_wdone = 1'b0; mbox_rdata = '0;
    last_g = NUM_CH - 1;
    exp_rdata = '0;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Single read by channel 1.
    set_req(1, 1'b0, 20'h00123, rnd_d());
    serve(3, 1'b0, 36'h9ABCD1234, g);
    chk("read_grant", 64'(grant), 64'(1));
    chk("read_rdata", 64'(ch_rdata), 64'h9ABCD1234);

    // Fairness: all four requesting, immediate completion.
    do_reset("fair_rst");
    for (int c = 0; c < NUM_CH; c++) set_req(c, 1'($urandom_range(0, 1)), rnd_a(), rnd_d());
    for (int i = 0; i < 5; i++) begin
      serve(1, 1'b0, rnd_d(), g);
      chk("fair_grant", 64'(grant), 64'(fair_seq[i]));
      set_req(g, 1'($urandom_range(0, 1)), rnd_a(), rnd_d());
    end
    ch_req = '0;

    // Timeout: channel 2 write never completes.
    set_req(2, 1'b1, rnd_a(), rnd_d());
    serve(TIMEOUT + 10, 1'b0, rnd_d(), g);
    chk("timeout_err", 64'(ch_err), 64'h4);
    chk("timeout_sel", 64'(mbox_sel), 64'(0));

    // Wrong strobe: dval during a channel 3 write, then wdone.
    set_req(3, 1'b1, rnd_a(), rnd_d());
    serve(5, 1'b1, rnd_d(), g);
    chk("wrong_strobe_ack", 64'(ch_ack), 64'h8);

    // Expiry tie: completion on the expiry edge.
    set_req(0, 1'b1, rnd_a(), rnd_d());
    serve(TIMEOUT, 1'b1, rnd_d(), g);
    chk("tie_ack", 64'(ch_ack), 64'h1);
    chk("tie_err", 64'(ch_err), 64'(0));

    // Mid-transaction reset, then a stray dval.
    set_req(0, 1'b0, rnd_a(), rnd_d());
    @(posedge clk); @(negedge clk);
    chk("midrst_busy", 64'(busy), 64'(1));
    @(posedge clk);
    do_reset("midrst");
    mbox_dval = 1'b1; mbox_rdata = rnd_d();
    @(posedge clk); @(negedge clk);
    mbox_dval = 1'b0;
    chk("midrst_no_ack", 64'({ch_ack, ch_err}), 64'(0));
    chk("midrst_idle", 64'(busy), 64'(0));
    chk("midrst_rdata", 64'(ch_rdata), 64'(0));

    // Randomized traffic.
    for (int t = 0; t < 300; t++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (!ch_req[c] && $urandom_range(0, 2) == 0)
          set_req(c, 1'($urandom_range(0, 1)), rnd_a(), rnd_d());
      end
      if (ch_req == '0) set_req($urandom_range(0, NUM_CH - 1), 1'($urandom_range(0, 1)), rnd_a(), rnd_d());
      // Occasional stray strobe on the grant edge (DUT is idle there).
      mbox_dval  = ($urandom_range(0, 4) == 0);
      mbox_wdone = ($urandom_range(0, 4) == 0);
      serve($urandom_range(1, TIMEOUT + 2), 1'b0, rnd_d(), g);
      if ($urandom_range(0, 1) == 1) set_req(g, 1'($urandom_range(0, 1)), rnd_a(), rnd_d());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
